// File: rtl/inst_fetch_byte_if.sv
// Fetch-unit bundle: byte memory port, redirect/stall inputs and IF/ID output.
// master = fetch unit, slave = memory and downstream pipeline.
interface inst_fetch_byte_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned INST_W = 32;

  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              stall_in;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              fetch_err;

  modport master (
    output mem_re, mem_addr, if_valid, if_pc, if_inst, fetch_err,
    input  mem_rdata, mem_ready, branch_en, branch_target, stall_in
  );

  modport slave (
    input  mem_re, mem_addr, if_valid, if_pc, if_inst, fetch_err,
    output mem_rdata, mem_ready, branch_en, branch_target, stall_in
  );
endinterface

// File: rtl/inst_fetch_byte.sv
// Byte-serial instruction fetch: assembles four bytes (pc+0 in the MSB lane)
// into one 32-bit instruction and hands it to IF/ID with a valid/stall handshake.
// Optional macro FETCH_TIMEOUT_EN adds a wait-cycle watchdog and FAULT state.
module inst_fetch_byte #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_byte_if.master  bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned BUF_W  = 24;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned WAIT_W = 8;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [BUF_W-1:0]  buf_q,    buf_d;
  logic [INST_W-1:0] inst_q,   inst_d;
  logic [ADDR_W-1:0] ifpc_q,   ifpc_d;
  logic              valid_q,  valid_d;
  logic              re_q,     re_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] target_al;
  logic [ADDR_W-1:0] pc_next_seq;

`ifdef FETCH_TIMEOUT_EN
  logic              err_q,    err_d;
  logic [WAIT_W-1:0] wait_q,   wait_d;
`endif

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign target_al   = {bus.branch_target[ADDR_W-1:2], 2'b00};
  assign pc_next_seq = pc_q + ADDR_W'(4);

  // Next-state and registered-output decode; redirect overrides every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    re_d    = re_q;
    addr_d  = addr_q;
`ifdef FETCH_TIMEOUT_EN
    err_d   = err_q;
    wait_d  = wait_q;
`endif

    if (bus.branch_en) begin
      state_d = S_FETCH;
      pc_d    = target_al;
      cnt_d   = '0;
      valid_d = 1'b0;
      re_d    = 1'b1;
      addr_d  = target_al;
`ifdef FETCH_TIMEOUT_EN
      err_d   = 1'b0;
      wait_d  = '0;
`endif
    end else begin
      case (state_q)
        S_BOOT: begin
          state_d = S_FETCH;
          re_d    = 1'b1;
          addr_d  = pc_q;
        end

        S_FETCH: begin
          if (bus.mem_ready) begin
`ifdef FETCH_TIMEOUT_EN
            wait_d = '0;
`endif
            // Shift bytes in so the byte at pc+0 ends up in the top lane.
            buf_d = {buf_q[BUF_W-9:0], bus.mem_rdata};
            if (cnt_q == CNT_W'(3)) begin
              inst_d  = {buf_q, bus.mem_rdata};
              ifpc_d  = pc_q;
              valid_d = 1'b1;
              re_d    = 1'b0;
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d  = cnt_inc;
              addr_d = pc_q + ADDR_W'(cnt_inc);
            end
          end else begin
`ifdef FETCH_TIMEOUT_EN
            if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
              state_d = S_FAULT;
              re_d    = 1'b0;
              err_d   = 1'b1;
              valid_d = 1'b0;
              wait_d  = '0;
              cnt_d   = '0;
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
`endif
          end
        end

        S_DONE: begin
          if (!bus.stall_in) begin
            pc_d    = pc_next_seq;
            state_d = S_FETCH;
            valid_d = 1'b0;
            re_d    = 1'b1;
            addr_d  = pc_next_seq;
          end
        end

`ifdef FETCH_TIMEOUT_EN
        S_FAULT: begin
          re_d    = 1'b0;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
`endif

        default: begin
          state_d = S_BOOT;
          re_d    = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset drops any partially fetched word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      buf_q   <= '0;
      inst_q  <= '0;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
      err_q   <= 1'b0;
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
`ifdef FETCH_TIMEOUT_EN
      err_q   <= err_d;
      wait_q  <= wait_d;
`endif
    end
  end

  assign bus.mem_re   = re_q;
  assign bus.mem_addr = addr_q;
  assign bus.if_valid = valid_q;
  assign bus.if_pc    = ifpc_q;
  assign bus.if_inst  = inst_q;

`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err = err_q;

  // Target alignment bits are dropped by design.
  logic unused_cfg;
  assign unused_cfg = ^{bus.branch_target[1:0]};
`else
  assign bus.fetch_err = 1'b0;

  // Timeout configuration and FAULT encoding have no effect in this build.
  logic unused_cfg;
  assign unused_cfg = ^{bus.branch_target[1:0], WAIT_W'(MAX_WAIT), S_FAULT};
`endif
endmodule

// File: doc/inst_fetch_byte.md
Name: inst_fetch_byte

Overview:
- Front end of the pipeline. Fetches each 32-bit instruction from a byte-wide instruction memory port, one byte per accepted access.
- Assembles the four bytes and presents {if_pc, if_inst} with a valid/stall handshake to the IF/ID pipeline register.
- Byte packing: byte at pc+0 goes to if_inst[31:24], byte at pc+3 goes to if_inst[7:0]. The IF/ID register byte-swaps this back to little-endian instruction order.
- Accepts branch redirects from later stages in any state.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- MAX_WAIT, 16, cycles without mem_ready before timeout fault. Used only when FETCH_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_re  output  1  byte read request.
- mem_addr  output  32  byte address, equal to pc + byte_cnt.
- mem_rdata  input  8  read byte; valid in the cycle mem_ready=1.
- mem_ready  input  1  memory accepts the request and returns mem_rdata in the same cycle.
- branch_en  input  1  redirect request.
- branch_target  input  32  redirect address; bits [1:0] are ignored and forced to 0.
- stall_in  input  1  downstream cannot accept an instruction this cycle.
- if_valid  output  1  if_pc and if_inst hold a complete instruction.
- if_pc  output  32  address of the presented instruction.
- if_inst  output  32  assembled instruction.
- fetch_err  output  1  timeout fault flag; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT, pc=RESET_PC, byte_cnt=0.
  - if_valid=0, if_pc=0, if_inst=0, mem_re=0, mem_addr=0, fetch_err=0.
  - Reset asserted mid-fetch discards all partial bytes immediately.
- States: BOOT, FETCH, DONE, FAULT. All outputs are registered or decoded from state only; no combinational path from mem_rdata to the if_* outputs.
- BOOT: mem_re=0. Moves to FETCH unconditionally on the first clock after reset deasserts.
- FETCH:
  - mem_re=1, mem_addr=pc+byte_cnt.
  - On mem_ready=1, store mem_rdata into lane byte_cnt (lane 0 = if_inst[31:24]) and increment byte_cnt.
  - If byte_cnt==3 when mem_ready=1: byte_cnt wraps to 0, state goes to DONE, if_valid=1 and if_pc=pc from the next cycle.
  - If mem_ready=0: hold all state and outputs.
- DONE:
  - mem_re=0; if_valid=1; if_pc and if_inst held stable.
  - stall_in=1: remain in DONE with outputs unchanged.
  - stall_in=0: instruction is consumed this edge; pc<=pc+4 (wraps modulo 2^32), state goes to FETCH, if_valid=0 next cycle.
- Latency: with mem_ready held at 1, the first if_valid occurs 5 cycles after reset release (1 BOOT + 4 FETCH). Sustained throughput is one instruction per 5 cycles.
- Redirect: branch_en=1 has priority over every other event in BOOT, FETCH, DONE and FAULT.
  - Next state: pc<={branch_target[31:2],2'b00}, byte_cnt=0, state=FETCH, if_valid=0, fetch_err=0.
  - Any partial word is discarded, including a byte returned by the memory in the same cycle.
  - In DONE with stall_in=0 and branch_en=1, the redirect wins: pc is set to the target, not pc+4.
- if_inst contents are don't-care while if_valid=0. The implementation keeps the last assembled word there.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter increments on each FETCH cycle with mem_ready=0 and clears on mem_ready=1, on state change, or on redirect.
  - When the counter reaches MAX_WAIT: state goes to FAULT, mem_re=0, fetch_err=1, if_valid=0.
  - FAULT is left only through branch_en=1 or reset.
- Not defined: no counter and no FAULT state; FETCH waits indefinitely; fetch_err is constant 0.

Test Plan:
- Reset release with RESET_PC=0, memory bytes 0x00..0x03 = 13 05 A0 00, mem_ready always 1 -> mem_addr sequence 0,1,2,3; if_valid=1 in the 5th cycle with if_pc=0, if_inst=32'h1305A000.
- Memory inserts 2 wait cycles on byte 2 -> mem_addr holds at 2 for 3 cycles; if_valid arrives 2 cycles later than the previous case; if_inst unchanged.
- stall_in=1 for 3 cycles while in DONE -> if_valid, if_pc, if_inst stable for those 3 cycles; the next fetch starts at mem_addr=4 only after stall_in falls.
- branch_en=1 with branch_target=32'h0000_0103 during byte 1 of a fetch -> partial word dropped; next mem_addr=0x100; next if_pc=0x100.
- rst asserted mid-fetch at byte 2 -> outputs clear immediately; after release the fetch restarts at RESET_PC from byte 0.
- With FETCH_TIMEOUT_EN and MAX_WAIT=4, mem_ready held at 0 -> fetch_err=1 and mem_re=0 after 4 waiting cycles; branch_en then clears fetch_err and resumes fetching.
